dmem_store_buffer: RTL

//  Data-memory side stage directly downstream of the multi-cycle RV32 core's data port.

---
 rtl/dmem_sb_pkg.sv | 28 ++
 rtl/sb_fifo.sv | 79 +++++++
 rtl/dmem_store_buffer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dmem_sb_pkg.sv
// Shared types and helpers for the data-memory store buffer.
//   SB_DEPTH    default number of buffered stores
//   SB_ADDR_W   SRAM word-address width
//   sb_entry_t  one buffered store: word address, byte strobes, lane-aligned data
//   byte_merge  overlays the strobed byte lanes of upd onto base
package dmem_sb_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 14;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [3:0]           strb;
        logic [31:0]          data;
    } sb_entry_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] base,
                                               input logic [31:0] upd,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = base;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = upd[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular FIFO holding pending stores.
// Build option: DMEM_STORE_FWD_EN adds the compare/age-order ports used for
// load forwarding; without it only the plain FIFO is built.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push_i, pop_i   enqueue push_entry_i at tail / dequeue head (may coincide)
//   head_entry_o    oldest entry
//   count_o         number of valid entries
//   cmp_addr_i      word address to compare against        (forwarding only)
//   match_o[k]      k-th oldest entry is valid and matches   (forwarding only)
//   aged_data_o/aged_strb_o[k]  data/strobes of k-th oldest  (forwarding only)
module sb_fifo
    import dmem_sb_pkg::*;
#(
    parameter  int DEPTH = SB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  sb_entry_t            push_entry_i,
`ifdef DMEM_STORE_FWD_EN
    input  logic [SB_ADDR_W-1:0] cmp_addr_i,
    output logic [DEPTH-1:0]     match_o,
    output logic [31:0]          aged_data_o [DEPTH],
    output logic [3:0]           aged_strb_o [DEPTH],
`endif
    output sb_entry_t            head_entry_o,
    output logic [CNT_W-1:0]     count_o
);

    sb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
        else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + PTR_W'(1);
            if (pop_i)  head_q <= head_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= push_entry_i;
    end

    assign head_entry_o = mem_q[head_q];
    assign count_o      = count_q;

`ifdef DMEM_STORE_FWD_EN
    // Rotate storage into age order (index 0 = oldest) so the consumer can
    // apply matches in ascending order and let the youngest win.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx            = head_q + PTR_W'(k);
            aged_data_o[k] = mem_q[idx].data;
            aged_strb_o[k] = mem_q[idx].strb;
            match_o[k]     = (CNT_W'(k) < count_q) && (mem_q[idx].addr == cmp_addr_i);
        end
    end
`endif

endmodule

// File: rtl/dmem_store_buffer.sv
// Store buffer between the RV32 core data port and a single-port sync SRAM.
// Stores are queued and drained in idle cycles; loads take the SRAM port first.
// Build option: DMEM_STORE_FWD_EN -- loads are byte-merged with pending stores
// and never wait; without it a load waits until the buffer has drained.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   cpu_addr/cpu_wstrb/cpu_wdata      store request (wstrb != 0) / load address
//   cpu_rd                            load request
//   cpu_rdata, cpu_rvalid             load result, one cycle after acceptance
//   cpu_stall                         request not accepted, core holds and retries
//   sb_empty                          no pending stores
//   mem_en/mem_we/mem_addr/mem_wdata  SRAM command (combinational)
//   mem_rdata                         SRAM read data, one cycle after a read
module dmem_store_buffer
    import dmem_sb_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_addr,
    input  logic [3:0]        cpu_wstrb,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_rd,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    output logic              sb_empty,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             st_req, full, push, pop, load_issue;
    logic [CNT_W-1:0] count;
    logic [ADDR_W-1:0] word_addr;
    sb_entry_t        new_entry, head_entry;
    logic             rvalid_q;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

    assign word_addr = cpu_addr[ADDR_W+1:2];
    assign st_req    = (cpu_wstrb != 4'b0);
    assign full      = (count == CNT_W'(DEPTH));
    assign sb_empty  = (count == '0);

    // A stall rejects the whole request (load and store alike), so a retried
    // request is never half-applied.
`ifdef DMEM_STORE_FWD_EN
    assign cpu_stall = st_req && full;
`else
    assign cpu_stall = (st_req && full) || (cpu_rd && !sb_empty);
`endif

    assign load_issue = cpu_rd && !cpu_stall && !rst;
    assign push       = st_req && !cpu_stall;
    assign pop        = !sb_empty && !load_issue;

    assign new_entry.addr = word_addr;
    assign new_entry.strb = cpu_wstrb;
    assign new_entry.data = cpu_wdata;

`ifdef DMEM_STORE_FWD_EN
    logic [DEPTH-1:0] match;
    logic [31:0]      aged_data [DEPTH];
    logic [3:0]       aged_strb [DEPTH];
    logic [31:0]      fwd_data_d, fwd_data_q;
    logic [3:0]       fwd_mask_d, fwd_mask_q;
`endif

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .push_entry_i (new_entry),
`ifdef DMEM_STORE_FWD_EN
        .cmp_addr_i   (word_addr),
        .match_o      (match),
        .aged_data_o  (aged_data),
        .aged_strb_o  (aged_strb),
`endif
        .head_entry_o (head_entry),
        .count_o      (count)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (load_issue) begin
            mem_en   = 1'b1;
            mem_addr = word_addr;
        end else if (pop) begin
            mem_en    = 1'b1;
            mem_we    = head_entry.strb;
            mem_addr  = ADDR_W'(head_entry.addr);
            mem_wdata = head_entry.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rvalid_q <= 1'b0;
        else     rvalid_q <= load_issue;
    end

    assign cpu_rvalid = rvalid_q;

`ifdef DMEM_STORE_FWD_EN
    // Overlay matching entries oldest first so the youngest store wins a lane.
    always_comb begin
        fwd_data_d = '0;
        fwd_mask_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match[k]) begin
                fwd_data_d = byte_merge(fwd_data_d, aged_data[k], aged_strb[k]);
                fwd_mask_d = fwd_mask_d | aged_strb[k];
            end
        end
    end

    // Snapshot at issue: a drain in the SRAM-read cycle must not change the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_data_q <= '0;
            fwd_mask_q <= '0;
        end else if (load_issue) begin
            fwd_data_q <= fwd_data_d;
            fwd_mask_q <= fwd_mask_d;
        end
    end

    assign cpu_rdata = rvalid_q ? byte_merge(mem_rdata, fwd_data_q, fwd_mask_q) : 32'h0;
`else
    assign cpu_rdata = rvalid_q ? mem_rdata : 32'h0;
`endif

endmodule
